// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the Tuse/Tnew hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned TNEW_W_DEF  = 3;
  localparam int unsigned SEL_W_DEF   = 2;
  // Tuse value meaning "this source is never read".
  localparam int unsigned TUSE_UNUSED = 3;
  // Forward-select encoding for "take the register file"; k>0 means stage k.
  localparam int unsigned SEL_RF      = 0;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage request / hazard-response bundle between D and the scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned TNEW_W = TNEW_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) ();

  logic              d_valid;
  reg_idx_t          d_rs;
  reg_idx_t          d_rt;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  reg_idx_t          d_dst;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_mdu_use;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              mdu_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_div, d_mdu_use,
    input  stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_div, d_mdu_use,
    output stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
  );

endinterface

// File: rtl/hazard_stage_rec.sv
// One in-flight destination record; ages tnew by one cycle when AGE is set.
module hazard_stage_rec
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned TNEW_W = TNEW_W_DEF,
  parameter bit          AGE    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              in_valid,
  input  reg_idx_t          in_dst,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_md,
  input  logic              in_div,
  output logic              valid,
  output reg_idx_t          dst,
  output logic [TNEW_W-1:0] tnew,
  output logic              md,
  output logic              div
);

  logic              valid_d, valid_q;
  reg_idx_t          dst_d, dst_q;
  logic [TNEW_W-1:0] tnew_d, tnew_q;
  logic              md_d, md_q;
  logic              div_d, div_q;

  // Next record: a bubble, or the incoming record with tnew saturating at 0.
  always_comb begin
    valid_d = in_valid;
    dst_d   = in_dst;
    tnew_d  = in_tnew;
    md_d    = in_md;
    div_d   = in_div;
    if (AGE && (in_tnew != '0)) begin
      tnew_d = in_tnew - TNEW_W'(1);
    end
    if (bubble) begin
      valid_d = 1'b0;
      md_d    = 1'b0;
      div_d   = 1'b0;
    end
  end

  // Record register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dst_q   <= '0;
      tnew_q  <= '0;
      md_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      tnew_q  <= tnew_d;
      md_q    <= md_d;
      div_q   <= div_d;
    end
  end

  assign valid = valid_q;
  assign dst   = dst_q;
  assign tnew  = tnew_q;
  assign md    = md_q;
  assign div   = div_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: record pipeline, D-stage stall, forwarding selects, MDU busy.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned TNEW_W   = TNEW_W_DEF,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(max_u(MULT_CYC, DIV_CYC) + 1);

  logic [DEPTH:1]    rec_valid;
  logic [DEPTH:1]    rec_md;
  logic [DEPTH:1]    rec_div;
  reg_idx_t          rec_dst  [DEPTH:1];
  logic [TNEW_W-1:0] rec_tnew [DEPTH:1];

  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              load_bubble_c;
  logic              mdu_busy_c;
  logic              stall_c;
  logic [1:0]        data_stall_c;
  logic [SEL_W-1:0]  sel_c  [2];
  reg_idx_t          src_c  [2];
  logic [TNEW_W-1:0] tuse_c [2];
  logic              unused_tail;

  // The oldest record's MDU flags have no further consumer.
  assign unused_tail = ^{rec_md[DEPTH], rec_div[DEPTH]};

  assign load_bubble_c = stall_c || !hz.d_valid;

  // Stage 1 loads from D without ageing; later stages age the record ahead.
  for (genvar k = 1; k <= int'(DEPTH); k++) begin : g_stage
    if (k == 1) begin : g_head
      hazard_stage_rec #(.TNEW_W(TNEW_W), .AGE(1'b0)) u_rec (
        .clk      (clk),
        .reset    (reset),
        .bubble   (load_bubble_c),
        .in_valid (hz.d_valid),
        .in_dst   (hz.d_dst),
        .in_tnew  (hz.d_tnew),
        .in_md    (hz.d_md_start),
        .in_div   (hz.d_md_div),
        .valid    (rec_valid[k]),
        .dst      (rec_dst[k]),
        .tnew     (rec_tnew[k]),
        .md       (rec_md[k]),
        .div      (rec_div[k])
      );
    end else begin : g_tail
      hazard_stage_rec #(.TNEW_W(TNEW_W), .AGE(1'b1)) u_rec (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (rec_valid[k-1]),
        .in_dst   (rec_dst[k-1]),
        .in_tnew  (rec_tnew[k-1]),
        .in_md    (rec_md[k-1]),
        .in_div   (rec_div[k-1]),
        .valid    (rec_valid[k]),
        .dst      (rec_dst[k]),
        .tnew     (rec_tnew[k]),
        .md       (rec_md[k]),
        .div      (rec_div[k])
      );
    end
  end

  assign src_c[0]  = hz.d_rs;
  assign src_c[1]  = hz.d_rt;
  assign tuse_c[0] = hz.d_rs_tuse;
  assign tuse_c[1] = hz.d_rt_tuse;

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic              hit_c;
    logic [TNEW_W-1:0] tnew_c;
    logic [SEL_W-1:0]  stage_c;

    // Scan oldest to youngest so the youngest matching record wins; $0 never matches.
    always_comb begin
      hit_c   = 1'b0;
      tnew_c  = '0;
      stage_c = SEL_W'(SEL_RF);
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (rec_valid[k] && (rec_dst[k] == src_c[s]) && (src_c[s] != '0)) begin
          hit_c   = 1'b1;
          tnew_c  = rec_tnew[k];
          stage_c = SEL_W'(k);
        end
      end
    end

    assign data_stall_c[s] = hit_c && (tnew_c > tuse_c[s]);
    assign sel_c[s]        = (hit_c && (tnew_c == '0)) ? stage_c : SEL_W'(SEL_RF);
  end

  // MDU busy counter: reload when an md op sits in E, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (rec_valid[1] && rec_md[1]) begin
      cnt_d = rec_div[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // MDU counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hazard outputs, combinational from the records and the D request.
  always_comb begin
    mdu_busy_c = (cnt_q != '0) || (rec_valid[1] && rec_md[1]);
    stall_c    = hz.d_valid && ((|data_stall_c) || (hz.d_mdu_use && mdu_busy_c));
  end

  assign hz.stall      = stall_c;
  assign hz.fwd_rs_sel = sel_c[0];
  assign hz.fwd_rt_sel = sel_c[1];
  assign hz.mdu_busy   = mdu_busy_c;

endmodule
